// File: rtl/imu_pkg.sv
// Shared constants and encodings for the IMU frame controller.
package imu_pkg;

    localparam logic [7:0] IMU_HDR     = 8'h55;
    localparam logic [7:0] IMU_T_ACC   = 8'h51;
    localparam logic [7:0] IMU_T_GYRO  = 8'h52;
    localparam logic [7:0] IMU_T_ANG   = 8'h53;
    localparam int         IMU_PAYLOAD_LEN = 8;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        TYPE    = 2'd1,
        PAYLOAD = 2'd2,
        SUM     = 2'd3
    } imu_state_e;

    // Low two bits of the type byte map directly onto this encoding.
    typedef enum logic [1:0] {
        FT_NONE = 2'd0,
        FT_ACC  = 2'd1,
        FT_GYRO = 2'd2,
        FT_ANG  = 2'd3
    } imu_ftype_e;

endpackage

// File: rtl/imu_byte_timer.sv
// Inter-byte watchdog: counts enabled cycles, pulses expire on the last count unless cleared.
module imu_byte_timer #(
    parameter int CYC = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A strobe in the expiry cycle wins over the timeout.
    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/imu_frame_ctrl.sv
// Frame sync, checksum check and atomic commit of 11-byte IMU frames.
// state   | meaning
// HUNT    | waiting for header 0x55
// TYPE    | header seen, waiting for type byte
// PAYLOAD | collecting 8 payload bytes
// SUM     | waiting for checksum byte
module imu_frame_ctrl
    import imu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [15:0] acc_x_o,
    output logic [15:0] acc_y_o,
    output logic [15:0] acc_z_o,
    output logic [15:0] gyro_x_o,
    output logic [15:0] gyro_y_o,
    output logic [15:0] gyro_z_o,
    output logic [15:0] ang_x_o,
    output logic [15:0] ang_y_o,
    output logic [15:0] ang_z_o,
    output logic [15:0] temp_o,
    output logic        frame_done_o,
    output logic [1:0]  frame_type_o,
    output logic        err_sum_o,
    output logic        err_type_o,
    output logic        err_timeout_o,
    output logic        in_sync_o
);
    imu_state_e state_q;
    imu_ftype_e type_q;
    logic [2:0] idx_q;
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic [IMU_PAYLOAD_LEN-1:0][7:0] buf_q;
    logic [15:0] w0, w1, w2, w3;
    logic expire;
    logic type_ok;

    assign sum_d   = sum_q + byte_data_i;
    assign type_ok = (byte_data_i == IMU_T_ACC) || (byte_data_i == IMU_T_GYRO) ||
                     (byte_data_i == IMU_T_ANG);
    assign w0 = {buf_q[1], buf_q[0]};
    assign w1 = {buf_q[3], buf_q[2]};
    assign w2 = {buf_q[5], buf_q[4]};
    assign w3 = {buf_q[7], buf_q[6]};

    imu_byte_timer #(.CYC(TIMEOUT_CYC)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (byte_valid_i || (state_q == HUNT)),
        .en_i     (state_q != HUNT),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            type_q        <= FT_NONE;
            idx_q         <= '0;
            sum_q         <= '0;
            buf_q         <= '0;
            acc_x_o       <= '0;
            acc_y_o       <= '0;
            acc_z_o       <= '0;
            gyro_x_o      <= '0;
            gyro_y_o      <= '0;
            gyro_z_o      <= '0;
            ang_x_o       <= '0;
            ang_y_o       <= '0;
            ang_z_o       <= '0;
            temp_o        <= '0;
            frame_done_o  <= 1'b0;
            frame_type_o  <= '0;
            err_sum_o     <= 1'b0;
            err_type_o    <= 1'b0;
            err_timeout_o <= 1'b0;
            in_sync_o     <= 1'b0;
        end else begin
            frame_done_o  <= 1'b0;
            err_sum_o     <= 1'b0;
            err_type_o    <= 1'b0;
            err_timeout_o <= 1'b0;
            if (byte_valid_i) begin
                case (state_q)
                    HUNT: begin
                        if (byte_data_i == IMU_HDR) begin
                            state_q   <= TYPE;
                            sum_q     <= IMU_HDR;
                            in_sync_o <= 1'b1;
                        end
                    end
                    TYPE: begin
                        if (type_ok) begin
                            state_q <= PAYLOAD;
                            type_q  <= imu_ftype_e'(byte_data_i[1:0]);
                            sum_q   <= sum_d;
                            idx_q   <= '0;
                        end else if (byte_data_i == IMU_HDR) begin
                            sum_q <= IMU_HDR;
                        end else begin
                            state_q    <= HUNT;
                            err_type_o <= 1'b1;
                            in_sync_o  <= 1'b0;
                        end
                    end
                    PAYLOAD: begin
                        buf_q[idx_q] <= byte_data_i;
                        sum_q        <= sum_d;
                        idx_q        <= idx_q + 1'b1;
                        if (idx_q == 3'(IMU_PAYLOAD_LEN - 1)) state_q <= SUM;
                    end
                    SUM: begin
                        state_q   <= HUNT;
                        in_sync_o <= 1'b0;
                        if (byte_data_i == sum_q) begin
                            frame_done_o <= 1'b1;
                            frame_type_o <= type_q;
                            temp_o       <= w3;
                            case (type_q)
                                FT_ACC:  begin acc_x_o  <= w0; acc_y_o  <= w1; acc_z_o  <= w2; end
                                FT_GYRO: begin gyro_x_o <= w0; gyro_y_o <= w1; gyro_z_o <= w2; end
                                FT_ANG:  begin ang_x_o  <= w0; ang_y_o  <= w1; ang_z_o  <= w2; end
                                default: ;
                            endcase
                        end else begin
                            err_sum_o <= 1'b1;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end else if (expire) begin
                state_q       <= HUNT;
                err_timeout_o <= 1'b1;
                in_sync_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imu_frame_ctrl.sv
// Directed bench for imu_frame_ctrl with a short inter-byte timeout.
module tb_imu_frame_ctrl;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [15:0] acc_x, acc_y, acc_z, gyro_x, gyro_y, gyro_z, ang_x, ang_y, ang_z, temp;
    logic        frame_done, err_sum, err_type, err_timeout, in_sync;
    logic [1:0]  frame_type;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0, n_esum = 0, n_etype = 0, n_eto = 0;
    int n_multi = 0;

    imu_frame_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_valid_i  (byte_valid),
        .byte_data_i   (byte_data),
        .acc_x_o       (acc_x),
        .acc_y_o       (acc_y),
        .acc_z_o       (acc_z),
        .gyro_x_o      (gyro_x),
        .gyro_y_o      (gyro_y),
        .gyro_z_o      (gyro_z),
        .ang_x_o       (ang_x),
        .ang_y_o       (ang_y),
        .ang_z_o       (ang_z),
        .temp_o        (temp),
        .frame_done_o  (frame_done),
        .frame_type_o  (frame_type),
        .err_sum_o     (err_sum),
        .err_type_o    (err_type),
        .err_timeout_o (err_timeout),
        .in_sync_o     (in_sync)
    );

    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle.
    always @(negedge clk) begin
        n_done  <= n_done  + int'(frame_done);
        n_esum  <= n_esum  + int'(err_sum);
        n_etype <= n_etype + int'(err_type);
        n_eto   <= n_eto   + int'(err_timeout);
        if ((32'(frame_done) + 32'(err_sum) + 32'(err_type) + 32'(err_timeout)) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the byte sampled.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // One idle cycle between bytes, none after the last one.
    task automatic send_bytes(input byte_q_t q);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (i != q.size() - 1) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    int d0, s0, t0, o0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_acc",   {acc_x, acc_y, acc_z}, 64'h0);
        chk("reset_gyro",  {gyro_x, gyro_y, gyro_z}, 64'h0);
        chk("reset_ang",   {ang_x, ang_y, ang_z, temp}, 64'h0);
        chk("reset_flags", {frame_type, frame_done, err_sum, err_type, err_timeout, in_sync}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good gyro frame
        send_byte(8'h55);
        chk("gyro_insync_after_hdr", in_sync, 1'b1);
        @(negedge clk);
        send_bytes('{8'h52, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'hAD});
        chk("gyro_done", frame_done, 1'b1);
        chk("gyro_type", frame_type, 2'd2);
        chk("gyro_xyz",  {gyro_x, gyro_y, gyro_z}, {16'h0001, 16'h0002, 16'h0003});
        chk("gyro_temp", temp, 16'h0000);
        chk("gyro_others", {acc_x, acc_y, acc_z, ang_x}, 64'h0);
        chk("gyro_insync_low", in_sync, 1'b0);
        @(negedge clk);
        chk("gyro_done_one_cycle", frame_done, 1'b0);

        // Bad checksums leave gyro registers alone
        send_bytes('{8'h55, 8'h52, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'hAE});
        chk("badsum_err", err_sum, 1'b1);
        chk("badsum_nodone", frame_done, 1'b0);
        @(negedge clk);
        chk("badsum_one_cycle", err_sum, 1'b0);
        send_bytes('{8'h55, 8'h52, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB1});
        chk("badsum2_err", err_sum, 1'b1);
        chk("badsum_gyro_hold", {gyro_x, gyro_y, gyro_z, temp}, {16'h0001, 16'h0002, 16'h0003, 16'h0000});
        @(negedge clk);

        // Header resync then acc frame
        settle();
        d0 = n_done; s0 = n_esum; t0 = n_etype; o0 = n_eto;
        @(negedge clk);
        send_bytes('{8'h55, 8'h55, 8'h55, 8'h51, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'hA4});
        chk("acc_type", frame_type, 2'd1);
        chk("acc_xyz", {acc_x, acc_y, acc_z}, {16'hFFFF, 16'h0000, 16'h0000});
        chk("acc_gyro_hold", {gyro_x, gyro_y, gyro_z}, {16'h0001, 16'h0002, 16'h0003});
        settle();
        chk("acc_pulses", {n_done - d0, n_esum - s0, n_etype - t0, n_eto - o0}, {32'd1, 32'd0, 32'd0, 32'd0});
        @(negedge clk);

        // Unknown type, then a good angle frame
        send_bytes('{8'h55, 8'h54});
        chk("type_err", err_type, 1'b1);
        chk("type_err_insync", in_sync, 1'b0);
        @(negedge clk);
        chk("type_err_one_cycle", err_type, 1'b0);
        send_bytes('{8'h55, 8'h53, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00, 8'h48});
        chk("ang_done", frame_done, 1'b1);
        chk("ang_type", frame_type, 2'd3);
        chk("ang_xyz_temp", {ang_x, ang_y, ang_z, temp}, {16'h0010, 16'h0020, 16'h0030, 16'h0040});
        chk("ang_acc_hold", {acc_x, acc_y, acc_z}, {16'hFFFF, 16'h0000, 16'h0000});
        @(negedge clk);

        // 0x55 in the payload is data
        send_bytes('{8'h55, 8'h53, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD});
        chk("hdr_in_payload_done", frame_done, 1'b1);
        chk("hdr_in_payload_ang", {ang_x, ang_y, ang_z, temp}, {16'h0055, 16'h0000, 16'h0000, 16'h0000});
        @(negedge clk);

        // Timeout after 16 idle cycles
        send_bytes('{8'h55, 8'h52, 8'h01});
        repeat (15) @(negedge clk);
        chk("to_not_yet", {err_timeout, in_sync}, 2'b01);
        @(negedge clk);
        chk("to_fire", {err_timeout, in_sync}, 2'b10);
        @(negedge clk);
        chk("to_one_cycle", err_timeout, 1'b0);

        // Byte on the expiry cycle keeps the frame alive
        send_bytes('{8'h55, 8'h52, 8'h01});
        repeat (15) @(negedge clk);
        send_byte(8'h02);
        chk("to_byte_on_expiry", {err_timeout, in_sync}, 2'b01);
        @(negedge clk);
        send_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA});
        chk("to_late_frame_done", frame_done, 1'b1);
        chk("to_late_gyro", {gyro_x, gyro_y, gyro_z}, {16'h0201, 16'h0000, 16'h0000});
        @(negedge clk);

        // Reset mid-frame
        send_bytes('{8'h55, 8'h51, 8'h11, 8'h22, 8'h33});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", {acc_x, gyro_x, gyro_y, ang_x}, 64'h0);
        chk("rst_mid_flags", {frame_type, frame_done, err_sum, err_type, err_timeout, in_sync, temp}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_bytes('{8'h55, 8'h51, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'hAD});
        chk("post_rst_done", frame_done, 1'b1);
        chk("post_rst_acc", {acc_x, acc_y, acc_z, temp}, {16'h0002, 16'h0000, 16'h0000, 16'h0005});
        chk("post_rst_others", {gyro_x, ang_x, 2'b00, frame_type}, {16'h0, 16'h0, 4'd1});

        settle();
        chk("pulse_mutex", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/imu_frame_ctrl.md
# imu_frame_ctrl

Frame-level controller that sits between the UART byte receiver and the attitude/threshold logic. It consumes the receiver's byte strobe stream, synchronises on the 11-byte IMU frame (header 0x55, type, 8 payload bytes, checksum) and verifies the checksum. It commits acceleration, angular-rate, angle and temperature words atomically into output registers, and recovers from line noise and stalls with an inter-byte timeout.

## Interface
- TIMEOUT_CYC, 25000: idle clk cycles between bytes, while mid-frame, before the frame is abandoned (1 ms at 25 MHz).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- byte_valid  in  1  one-cycle strobe: byte_data holds a received byte.
- byte_data  in  8  received byte.
- acc_x, acc_y, acc_z  out  16 each  last good type-0x51 words.
- gyro_x, gyro_y, gyro_z  out  16 each  last good type-0x52 words.
- ang_x, ang_y, ang_z  out  16 each  last good type-0x53 words.
- temp  out  16  temperature word from the last good frame of any type.
- frame_done  out  1  one-cycle pulse when a good frame is committed.
- frame_type  out  2  type of the last committed frame: 1 = acc, 2 = gyro, 3 = angle.
- err_sum, err_type, err_timeout  out  1 each  one-cycle error pulses.
- in_sync  out  1  high whenever the FSM is not in HUNT.

## Operation
- FSM states:
  - HUNT:
    - byte 0x55 -> TYPE; any other byte is ignored.
  - TYPE:
    - byte 0x51, 0x52 or 0x53 -> PAYLOAD, and the type is latched.
    - byte 0x55 -> stay in TYPE (header resync, no error).
    - any other byte -> HUNT, err_type.
  - PAYLOAD:
    - Bytes are stored in an 8-byte buffer indexed by a 3-bit counter.
    - When the counter reaches 7 on a strobe -> SUM.
  - SUM:
    - The received byte is compared with the running sum.
    - Equal -> commit, then HUNT.
    - Unequal -> HUNT, err_sum, and no output register changes.
- Checksum is the modulo-256 sum of all 10 preceding bytes, including 0x55 and the type byte. It is accumulated in an 8-bit register and cleared when a header is accepted.
- Payload words are little-endian: word0 = {b1,b0} maps to x, word1 = {b3,b2} to y, word2 = {b5,b4} to z, word3 = {b7,b6} to temp.
- Commit writes only the three words for the latched type plus temp; the other groups hold their values.
- Timeout:
  - A counter is cleared on every byte_valid and on entry to HUNT. It increments each cycle in TYPE, PAYLOAD or SUM.
  - Counter at TIMEOUT_CYC-1 with no byte_valid in that cycle -> HUNT, err_timeout.
  - byte_valid in the same cycle as expiry: the byte is processed and the timeout is not taken.
- A byte 0x55 inside PAYLOAD or SUM is treated as data, never as a resync.
- Reset mid-frame: FSM goes to HUNT; buffer, sum, counters and all outputs return to 0.

## Timing
- All outputs are registered. Reset value of every output, including in_sync, is 0.
- Commit latency: the data registers, frame_type and the frame_done pulse update on the clock edge that samples the checksum strobe, and are visible the following cycle.
- Error pulses follow the same latency and last exactly one cycle.
- At most one of frame_done, err_sum, err_type, err_timeout is high in any cycle.
- in_sync goes high the cycle after the header is accepted. It goes low the cycle after returning to HUNT.
- Back-to-back frames need no gap: a 0x55 strobe one cycle after the checksum strobe is accepted as a new header.
- byte_valid strobes spaced by at least one cycle are supported. No backpressure exists.

## Structure
- Package imu_pkg holds:
  - constants IMU_HDR = 8'h55, IMU_T_ACC = 8'h51, IMU_T_GYRO = 8'h52, IMU_T_ANG = 8'h53, IMU_PAYLOAD_LEN = 8;
  - the FSM state enum (HUNT, TYPE, PAYLOAD, SUM);
  - the 2-bit frame_type encoding.
- Sub-module imu_byte_timer: parameterised watchdog counter with clear, enable and expire-pulse ports, used for the inter-byte timeout.

## Test plan
- Good gyro frame: 55 52 01 00 02 00 03 00 00 00 AD -> gyro_x = 0x0001, gyro_y = 0x0002, gyro_z = 0x0003, temp = 0x0000; frame_type = 2; frame_done for one cycle; acc and angle registers unchanged.
- Bad checksum: same gyro frame with last byte AE -> err_sum for one cycle; gyro registers keep their prior values; no frame_done.
- Resync, then good acc frame:
  - Stimulus: 55 55 55 51 FF FF 00 00 00 00 00 00 A4.
  - Response: acc_x = 0xFFFF, acc_y = acc_z = 0; frame_type = 1; no error pulses.
- Unknown type: 55 54 -> err_type; the next valid frame is accepted normally.
- Timeout with TIMEOUT_CYC = 16: 55 52 01, then 16 idle cycles -> err_timeout; in_sync drops. A byte arriving exactly on the expiry cycle -> no timeout.
- Reset mid-frame: rst_n asserted after byte 5 of a frame -> all outputs 0; the subsequent complete frame commits correctly.
